// File: rtl/fu_config_loader_pkg.sv
// Shared definitions for the FU configuration loader: FSM states, control-word
// field positions and the limits that make a control word illegal.
package fu_config_loader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_CTRL = 2'd1,
        LOAD_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int ALU_SEL_LSB     = 0;
    localparam int ALU_SEL_W       = 4;
    localparam int CMP_SEL_BIT     = 4;
    localparam int OUT_SEL_LSB     = 5;
    localparam int OUT_SEL_W       = 2;
    localparam int FEEDBACK_BIT    = 7;
    localparam int CTRL_FIELD_BITS = 8;

    localparam logic [3:0] ALU_SEL_MAX     = 4'd8;
    localparam logic [1:0] OUT_SEL_ILLEGAL = 2'd3;

    typedef struct packed {
        logic       feedback;
        logic [1:0] out_sel;
        logic       cmp_sel;
        logic [3:0] alu_sel;
    } ctrl_fields_t;

endpackage

// File: rtl/fu_config_loader_if.sv
// Valid/ready config stream feeding the loader; the source drives data and valid.
interface fu_config_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] cfg_data;
    logic                  cfg_valid;
    logic                  cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/fu_cfg_word_decode.sv
// Splits a control word into its FU fields and flags words that use reserved
// encodings or set any bit above the defined fields.
module fu_cfg_word_decode
    import fu_config_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    output ctrl_fields_t          fields,
    output logic                  illegal
);

    logic [DATA_WIDTH-1:0] upper;

    always_comb begin
        fields.alu_sel  = word[ALU_SEL_LSB +: ALU_SEL_W];
        fields.cmp_sel  = word[CMP_SEL_BIT];
        fields.out_sel  = word[OUT_SEL_LSB +: OUT_SEL_W];
        fields.feedback = word[FEEDBACK_BIT];
        upper           = word >> CTRL_FIELD_BITS;
        illegal         = (fields.alu_sel > ALU_SEL_MAX)
                       || (fields.out_sel == OUT_SEL_ILLEGAL)
                       || (upper != '0);
    end

endmodule

// File: rtl/fu_config_loader.sv
// Loads a control word then an initial-data word for each FU in turn, holding
// the FUs in reset until every entry has been written.
module fu_config_loader
    import fu_config_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_FU     = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                start_i,
    fu_config_loader_if.slave                   cfg,
    output logic [NUM_FU-1:0][DATA_WIDTH-1:0]   initial_data_o,
    output logic [NUM_FU-1:0]                   feedback_o,
    output logic [NUM_FU-1:0][3:0]              alu_sel_o,
    output logic [NUM_FU-1:0]                   cmp_sel_o,
    output logic [NUM_FU-1:0][1:0]              out_sel_o,
    output logic                                fu_rst_no,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                err_o
);

    localparam int               IDX_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FU - 1);

    state_t           state;
    logic [IDX_W-1:0] fu_idx;
    logic             loading;
    logic             loaded;
    logic             accept;
    ctrl_fields_t     fields;
    logic             illegal;

    fu_cfg_word_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .word    (cfg.cfg_data),
        .fields  (fields),
        .illegal (illegal)
    );

    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg.cfg_ready = loading;
    assign busy_o        = loading;
    assign done_o        = loaded;
    assign fu_rst_no     = loaded;

    // loading/loaded are registered alongside the state so ready, busy, done
    // and the FU reset change only on state transitions.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            fu_idx         <= '0;
            loading        <= 1'b0;
            loaded         <= 1'b0;
            err_o          <= 1'b0;
            initial_data_o <= '0;
            feedback_o     <= '0;
            alu_sel_o      <= '0;
            cmp_sel_o      <= '0;
            out_sel_o      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state   <= LOAD_CTRL;
                        fu_idx  <= '0;
                        loading <= 1'b1;
                        loaded  <= 1'b0;
                        err_o   <= 1'b0;
                    end
                end
                LOAD_CTRL: begin
                    if (accept) begin
                        alu_sel_o[fu_idx]  <= fields.alu_sel;
                        cmp_sel_o[fu_idx]  <= fields.cmp_sel;
                        out_sel_o[fu_idx]  <= fields.out_sel;
                        feedback_o[fu_idx] <= fields.feedback;
                        if (illegal) begin
                            err_o <= 1'b1;
                        end
                        state <= LOAD_DATA;
                    end
                end
                LOAD_DATA: begin
                    if (accept) begin
                        initial_data_o[fu_idx] <= cfg.cfg_data;
                        if (fu_idx == LAST_IDX) begin
                            state   <= DONE;
                            loading <= 1'b0;
                            loaded  <= 1'b1;
                        end else begin
                            fu_idx <= fu_idx + 1'b1;
                            state  <= LOAD_CTRL;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    loading <= 1'b0;
                    loaded  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fu_config_loader.sv
// Drives directed and random config streams into the loader and compares its
// outputs against a transaction-level model of the per-FU configuration.
module tb_fu_config_loader;

    localparam int DW = 32;
    localparam int NF = 2;

    logic                   clk_i   = 1'b0;
    logic                   rst_ni  = 1'b0;
    logic                   start_i = 1'b0;
    logic [NF-1:0][DW-1:0]  initial_data;
    logic [NF-1:0]          feedback;
    logic [NF-1:0][3:0]     alu_sel;
    logic [NF-1:0]          cmp_sel;
    logic [NF-1:0][1:0]     out_sel;
    logic                   fu_rst_n;
    logic                   busy;
    logic                   done;
    logic                   err;

    fu_config_loader_if #(.DATA_WIDTH(DW)) cfg_bus ();

    fu_config_loader #(
        .DATA_WIDTH (DW),
        .NUM_FU     (NF)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .cfg            (cfg_bus),
        .initial_data_o (initial_data),
        .feedback_o     (feedback),
        .alu_sel_o      (alu_sel),
        .cmp_sel_o      (cmp_sel),
        .out_sel_o      (out_sel),
        .fu_rst_no      (fu_rst_n),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] stream [2*NF];
    logic [DW-1:0] exp_init [NF];
    logic [3:0]    exp_alu  [NF];
    logic          exp_cmp  [NF];
    logic [1:0]    exp_out  [NF];
    logic          exp_fb   [NF];
    logic          exp_err;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic modelClear();
        for (int f = 0; f < NF; f++) begin
            exp_init[f] = '0;
            exp_alu[f]  = '0;
            exp_cmp[f]  = 1'b0;
            exp_out[f]  = '0;
            exp_fb[f]   = 1'b0;
        end
        exp_err = 1'b0;
    endtask

    task automatic modelCtrl(input int fu, input logic [DW-1:0] w);
        logic [DW-1:0] hi;
        hi          = w >> 8;
        exp_alu[fu] = w[3:0];
        exp_cmp[fu] = w[4];
        exp_out[fu] = w[6:5];
        exp_fb[fu]  = w[7];
        if (w[3:0] > 4'd8 || w[6:5] == 2'd3 || hi != 0) exp_err = 1'b1;
    endtask

    task automatic checkAll(input string tag);
        logic [NF-1:0][DW-1:0] e_init;
        logic [NF-1:0][3:0]    e_alu;
        logic [NF-1:0][1:0]    e_out;
        logic [NF-1:0]         e_cmp;
        logic [NF-1:0]         e_fb;
        for (int f = 0; f < NF; f++) begin
            e_init[f] = exp_init[f];
            e_alu[f]  = exp_alu[f];
            e_out[f]  = exp_out[f];
            e_cmp[f]  = exp_cmp[f];
            e_fb[f]   = exp_fb[f];
        end
        checkOutput({tag, "_init"}, initial_data, e_init);
        checkOutput({tag, "_alu"}, alu_sel, e_alu);
        checkOutput({tag, "_out"}, out_sel, e_out);
        checkOutput({tag, "_cmp"}, cmp_sel, e_cmp);
        checkOutput({tag, "_fb"}, feedback, e_fb);
        checkOutput({tag, "_err"}, err, exp_err);
    endtask

    task automatic startLoad();
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        exp_err = 1'b0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_ready", cfg_bus.cfg_ready, 1);
        checkOutput("start_done", done, 0);
        checkOutput("start_fu_rst", fu_rst_n, 0);
        checkOutput("start_err", err, 0);
    endtask

    // Offers one word after an optional stall; returns once it has been taken.
    task automatic sendWord(input logic [DW-1:0] w, input int gap, input bit poke_start);
        int waited;
        cfg_bus.cfg_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            start_i = poke_start;
            cfg_bus.cfg_data = $urandom;
            @(posedge clk_i);
            #1;
            checkOutput("stall_busy", busy, 1);
        end
        start_i = 1'b0;
        cfg_bus.cfg_data  = w;
        cfg_bus.cfg_valid = 1'b1;
        waited = 0;
        while (!cfg_bus.cfg_ready && waited < 20) begin
            @(posedge clk_i);
            #1;
            waited++;
        end
        if (waited == 20) begin
            checkOutput("accept_timeout", 0, 1);
        end else begin
            @(posedge clk_i);
            #1;
        end
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_data  = $urandom;
    endtask

    task automatic applyStimulus(input int min_gap, input int max_gap, input bit poke_start);
        for (int f = 0; f < NF; f++) begin
            sendWord(stream[2*f], $urandom_range(max_gap, min_gap), poke_start);
            modelCtrl(f, stream[2*f]);
            checkOutput("ctrl_visible", alu_sel[f], exp_alu[f]);
            checkOutput("ctrl_err", err, exp_err);
            checkOutput("ctrl_busy", busy, 1);
            sendWord(stream[2*f+1], $urandom_range(max_gap, min_gap), poke_start);
            exp_init[f] = stream[2*f+1];
            checkOutput("data_visible", initial_data[f], exp_init[f]);
        end
        checkOutput("end_done", done, 1);
        checkOutput("end_fu_rst", fu_rst_n, 1);
        checkOutput("end_busy", busy, 0);
        checkOutput("end_ready", cfg_bus.cfg_ready, 0);
        checkAll("load");
    endtask

    function automatic logic [DW-1:0] randCtrl();
        logic [DW-1:0] w;
        w      = '0;
        w[3:0] = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 9)) : 4'($urandom_range(8, 0));
        w[4]   = 1'($urandom_range(1, 0));
        w[6:5] = ($urandom_range(7, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
        w[7]   = 1'($urandom_range(1, 0));
        if ($urandom_range(9, 0) == 0) w[DW-1:8] = 24'($urandom_range(255, 1));
        return w;
    endfunction

    task automatic setBaseStream();
        stream[0] = 32'h0000_0085;
        stream[1] = 32'h0000_0010;
        stream[2] = 32'h0000_0021;
        stream[3] = 32'hFFFF_FFFF;
    endtask

    initial begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_data  = '0;
        modelClear();
        #12;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ready", cfg_bus.cfg_ready, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_fu_rst", fu_rst_n, 0);
        checkAll("reset");
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_done", done, 0);

        $display("[TB] back-to-back base stream");
        setBaseStream();
        startLoad();
        applyStimulus(0, 0, 1'b0);
        checkOutput("base_alu0", alu_sel[0], 5);
        checkOutput("base_fb0", feedback[0], 1);
        checkOutput("base_init0", initial_data[0], 32'h10);
        checkOutput("base_alu1", alu_sel[1], 1);
        checkOutput("base_out1", out_sel[1], 1);
        checkOutput("base_init1", initial_data[1], 32'hFFFF_FFFF);

        $display("[TB] stalled base stream");
        startLoad();
        applyStimulus(3, 3, 1'b0);

        $display("[TB] illegal control word");
        stream[0] = 32'h0000_0009;
        stream[1] = 32'h0000_ABCD;
        stream[2] = 32'h0000_0085;
        stream[3] = 32'h0000_0001;
        startLoad();
        applyStimulus(0, 2, 1'b1);
        checkOutput("illegal_err", err, 1);
        checkOutput("illegal_alu", alu_sel[0], 9);

        $display("[TB] restart from done");
        startLoad();
        checkOutput("restart_keep_alu", alu_sel[0], 9);
        checkOutput("restart_keep_init", initial_data[1], 32'h1);
        setBaseStream();
        applyStimulus(0, 1, 1'b1);

        $display("[TB] reset mid-load");
        startLoad();
        sendWord(stream[0], 0, 1'b0);
        sendWord(stream[1], 1, 1'b0);
        sendWord(stream[2], 0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        modelClear();
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_ready", cfg_bus.cfg_ready, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_fu_rst", fu_rst_n, 0);
        checkAll("midrst");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("postrst_busy", busy, 0);
        checkOutput("postrst_alu", alu_sel, 0);
        startLoad();
        applyStimulus(0, 2, 1'b0);
        checkOutput("postrst_err", err, 0);

        $display("[TB] random loads");
        for (int n = 0; n < 20; n++) begin
            for (int f = 0; f < NF; f++) begin
                stream[2*f]   = randCtrl();
                stream[2*f+1] = $urandom;
            end
            startLoad();
            applyStimulus(0, 3, 1'($urandom_range(1, 0)));
            repeat ($urandom_range(3, 0)) @(posedge clk_i);
            #1;
            checkOutput("rand_hold_done", done, 1);
            checkAll("rand_hold");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
